// File: rtl/scaler_pkg.sv
// scaler_pkg: algorithm codes, sequencer state encoding and bus widths shared by the scaler blocks.
// Rev 1.0
`default_nettype none
package scaler_pkg;
  localparam int SRC_ADDR_W     = 17;
  localparam int DEST_ADDR_W    = 19;
  localparam int PIX_W          = 8;
  localparam int DEF_SRC_WIDTH  = 320;
  localparam int DEF_DEST_WIDTH = 640;

  localparam logic [2:0] ALGO_REPLICATION = 3'b001;
  localparam logic [2:0] ALGO_DECIMATION  = 3'b010;
  localparam logic [2:0] ALGO_BLOCK_AVG   = 3'b011;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_ADVANCE = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  function automatic logic algo_supported(input logic [2:0] algo);
    return (algo == ALGO_REPLICATION) || (algo == ALGO_DECIMATION) || (algo == ALGO_BLOCK_AVG);
  endfunction

  function automatic logic [1:0] last_read_idx(input logic [2:0] algo);
    return (algo == ALGO_BLOCK_AVG) ? 2'd3 : 2'd0;
  endfunction

  function automatic logic [1:0] last_write_idx(input logic [2:0] algo);
    return (algo == ALGO_REPLICATION) ? 2'd3 : 2'd0;
  endfunction
endpackage
`default_nettype wire

// File: rtl/rd_latency_tracker.sv
// rd_latency_tracker: tags each ROM read and strobes its index in the cycle its data is due.
// Rev 1.0
`default_nettype none
module rd_latency_tracker #(
  parameter int MEM_RD_LAT = 2
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_issue_vld,
  input  logic [1:0] i_issue_idx,
  output logic       o_cap_vld,
  output logic [1:0] o_cap_idx
);
  logic [MEM_RD_LAT-1:0]      r_vld;
  logic [MEM_RD_LAT-1:0][1:0] r_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      r_idx <= '0;
    end else begin
      r_vld[0] <= i_issue_vld;
      r_idx[0] <= i_issue_idx;
      for (int i = 1; i < MEM_RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  assign o_cap_vld = r_vld[MEM_RD_LAT-1];
  assign o_cap_idx = r_idx[MEM_RD_LAT-1];
endmodule
`default_nettype wire

// File: rtl/scaler_mem_sequencer.sv
// scaler_mem_sequencer: fetches source pixels from ROM, writes scaled pixels to the framebuffer.
// Optional cycle counter enabled by SCALER_PERF_CNT_EN.  Rev 1.0
`default_nettype none
module scaler_mem_sequencer
  import scaler_pkg::*;
#(
  parameter int SRC_WIDTH  = scaler_pkg::DEF_SRC_WIDTH,
  parameter int DEST_WIDTH = scaler_pkg::DEF_DEST_WIDTH,
  parameter int MEM_RD_LAT = 2
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             algo_in,
  output logic [2:0]             selected_algo,
  input  logic [SRC_ADDR_W-1:0]  src_addr_in,
  input  logic [DEST_ADDR_W-1:0] dest_addr_in,
  input  logic                   process_finished_in,
  input  logic [PIX_W-1:0]       avg_pixel_in,
  output logic                   update_counters_en,
  output logic [PIX_W-1:0]       p00_out,
  output logic [PIX_W-1:0]       p01_out,
  output logic [PIX_W-1:0]       p10_out,
  output logic [PIX_W-1:0]       p11_out,
  output logic [SRC_ADDR_W-1:0]  rom_addr,
  input  logic [PIX_W-1:0]       rom_q,
  output logic [DEST_ADDR_W-1:0] fb_addr,
  output logic [PIX_W-1:0]       fb_data,
  output logic                   fb_we,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [31:0]            cycle_count
);
  localparam logic [SRC_ADDR_W-1:0]  SRC_PITCH  = SRC_ADDR_W'(SRC_WIDTH);
  localparam logic [DEST_ADDR_W-1:0] DEST_PITCH = DEST_ADDR_W'(DEST_WIDTH);

  logic [2:0]             r_state, w_next;
  logic [2:0]             r_algo;
  logic [1:0]             r_rd_idx, r_wr_idx;
  logic                   r_err;
  logic [PIX_W-1:0]       r_p00, r_p01, r_p10, r_p11;
  logic                   w_accept, w_last_rd, w_last_wr, w_cap_vld;
  logic [1:0]             w_cap_idx;
  logic [SRC_ADDR_W-1:0]  w_src_off;
  logic [DEST_ADDR_W-1:0] w_dest_off;

  assign w_accept  = (r_state == S_IDLE) && start && algo_supported(algo_in);
  assign w_last_rd = (r_rd_idx == last_read_idx(r_algo));
  assign w_last_wr = (r_wr_idx == last_write_idx(r_algo));

  rd_latency_tracker #(.MEM_RD_LAT(MEM_RD_LAT)) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .i_issue_vld (r_state == S_FETCH),
    .i_issue_idx (r_rd_idx),
    .o_cap_vld   (w_cap_vld),
    .o_cap_idx   (w_cap_idx)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_FETCH;
      S_FETCH:   if (w_last_rd) w_next = S_WAIT;
      // Leave WAIT only once the final read of this pixel has been captured.
      S_WAIT:    if (w_cap_vld && (w_cap_idx == last_read_idx(r_algo))) w_next = S_WRITE;
      S_WRITE:   if (w_last_wr) w_next = S_ADVANCE;
      S_ADVANCE: w_next = S_CHECK;
      S_CHECK:   w_next = process_finished_in ? S_DONE : S_FETCH;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (r_rd_idx)
      2'd0:    w_src_off = '0;
      2'd1:    w_src_off = SRC_ADDR_W'(1);
      2'd2:    w_src_off = SRC_PITCH;
      default: w_src_off = SRC_PITCH + SRC_ADDR_W'(1);
    endcase
    case (r_wr_idx)
      2'd0:    w_dest_off = '0;
      2'd1:    w_dest_off = DEST_ADDR_W'(1);
      2'd2:    w_dest_off = DEST_PITCH;
      default: w_dest_off = DEST_PITCH + DEST_ADDR_W'(1);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_algo   <= '0;
      r_rd_idx <= '0;
      r_wr_idx <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == S_IDLE) && start && !algo_supported(algo_in);
      if (w_accept) r_algo <= algo_in;
      if (r_state == S_FETCH) r_rd_idx <= w_last_rd ? 2'd0 : r_rd_idx + 2'd1;
      if (r_state == S_WRITE) r_wr_idx <= w_last_wr ? 2'd0 : r_wr_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p00 <= '0;
      r_p01 <= '0;
      r_p10 <= '0;
      r_p11 <= '0;
    end else if (w_cap_vld) begin
      case (w_cap_idx)
        2'd0:    r_p00 <= rom_q;
        2'd1:    r_p01 <= rom_q;
        2'd2:    r_p10 <= rom_q;
        default: r_p11 <= rom_q;
      endcase
    end
  end

  assign rom_addr           = (r_state == S_FETCH) ? src_addr_in + w_src_off : '0;
  assign fb_we              = (r_state == S_WRITE);
  assign fb_addr            = fb_we ? dest_addr_in + w_dest_off : '0;
  assign fb_data            = !fb_we ? '0 : ((r_algo == ALGO_BLOCK_AVG) ? avg_pixel_in : r_p00);
  assign update_counters_en = (r_state == S_ADVANCE);
  assign busy               = (r_state != S_IDLE);
  assign done               = (r_state == S_DONE);
  assign err                = r_err;
  assign selected_algo      = r_algo;
  assign p00_out            = r_p00;
  assign p01_out            = r_p01;
  assign p10_out            = r_p10;
  assign p11_out            = r_p11;

`ifdef SCALER_PERF_CNT_EN
  logic [31:0] r_cycle_count;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_count <= '0;
    end else if (w_accept) begin
      r_cycle_count <= '0;
    end else if (busy && (r_cycle_count != 32'hFFFF_FFFF)) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end
  assign cycle_count = r_cycle_count;
`else
  assign cycle_count = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_scaler_mem_sequencer.sv
// tb_scaler_mem_sequencer: directed frames against a cycle-timeline model of the sequencer.
// Rev 1.0
`default_nettype none
module tb_scaler_mem_sequencer;
  import scaler_pkg::*;
  localparam int L  = 2;
  localparam int SW = 320;
  localparam int DW = 640;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0]  algo_in = 3'b000, selected_algo;
  logic [16:0] src_addr_in, rom_addr;
  logic [18:0] dest_addr_in, fb_addr;
  logic        process_finished_in, update_counters_en, fb_we, busy, done, err;
  logic [7:0]  avg_pixel_in = 8'd0, p00_out, p01_out, p10_out, p11_out, rom_q, fb_data;
  logic [31:0] cycle_count;

  scaler_mem_sequencer #(.SRC_WIDTH(SW), .DEST_WIDTH(DW), .MEM_RD_LAT(L)) dut (
    .clk(clk), .reset(reset), .start(start), .algo_in(algo_in), .selected_algo(selected_algo),
    .src_addr_in(src_addr_in), .dest_addr_in(dest_addr_in), .process_finished_in(process_finished_in),
    .avg_pixel_in(avg_pixel_in), .update_counters_en(update_counters_en),
    .p00_out(p00_out), .p01_out(p01_out), .p10_out(p10_out), .p11_out(p11_out),
    .rom_addr(rom_addr), .rom_q(rom_q), .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .busy(busy), .done(done), .err(err), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // ROM: fixed contents, data appears L cycles after its address.
  function automatic logic [7:0] rom_val(input logic [16:0] a);
    case (a)
      17'd0:   return 8'd10;
      17'd1:   return 8'd20;
      17'd320: return 8'd30;
      17'd321: return 8'd41;
      default: return a[7:0];
    endcase
  endfunction
  logic [7:0] rom_pipe [L];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_val(rom_addr);
    for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_q = rom_pipe[L-1];

  // ULA stand-in: per-pixel address lists, registered pixel index.
  logic [16:0] f_src [4];
  logic [18:0] f_dst [4];
  int ula_idx = 0, ula_n = 0;
  bit ula_clr = 1'b0;
  always @(posedge clk) begin
    if (ula_clr) ula_idx <= 0;
    else if (update_counters_en) ula_idx <= ula_idx + 1;
  end
  assign src_addr_in         = f_src[(ula_idx < ula_n) ? ula_idx : 0];
  assign dest_addr_in        = f_dst[(ula_idx < ula_n) ? ula_idx : 0];
  assign process_finished_in = (ula_idx >= ula_n);

  // Expected per-cycle outputs, cycle 0 = first cycle after the accepted start.
  bit        e_rd[], e_we[], e_upd[], e_busy[], e_done[];
  bit [16:0] e_ra[];
  bit [18:0] e_fa[];
  bit [7:0]  e_fd[];
  int        e_T = 0;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;
  int chk_k = 0;
  int obs_wa[$], obs_wd[$], obs_rd[$], obs_upd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        if (chk_k <= e_T) begin
          if (e_rd[chk_k]) begin
            check("rom_addr", 32'(rom_addr), 32'(e_ra[chk_k]));
            obs_rd.push_back(int'(rom_addr));
          end
          check("fb_we", 32'(fb_we), 32'(e_we[chk_k]));
          check("fb_addr", 32'(fb_addr), 32'(e_fa[chk_k]));
          check("fb_data", 32'(fb_data), 32'(e_fd[chk_k]));
          check("update_counters_en", 32'(update_counters_en), 32'(e_upd[chk_k]));
          check("busy", 32'(busy), 32'(e_busy[chk_k]));
          check("done", 32'(done), 32'(e_done[chk_k]));
          check("err_idle", 32'(err), 32'd0);
          if (fb_we) begin
            obs_wa.push_back(int'(fb_addr));
            obs_wd.push_back(int'(fb_data));
          end
          if (update_counters_en) obs_upd.push_back(chk_k);
        end
        chk_k++;
      end else begin
        chk_k = 0;
        obs_wa.delete(); obs_wd.delete(); obs_rd.delete(); obs_upd.delete();
      end
    end
  endtask

  task automatic build_model(input logic [2:0] algo, input int n, input logic [7:0] avg);
    int nr, nw, plen, b, k;
    bit [16:0] soff [4];
    bit [18:0] doff [4];
    soff[0] = 17'd0; soff[1] = 17'd1; soff[2] = 17'(SW); soff[3] = 17'(SW + 1);
    doff[0] = 19'd0; doff[1] = 19'd1; doff[2] = 19'(DW); doff[3] = 19'(DW + 1);
    nr   = (algo == ALGO_BLOCK_AVG) ? 4 : 1;
    nw   = (algo == ALGO_REPLICATION) ? 4 : 1;
    plen = nr + L + nw + 2;
    e_T  = n * plen + 1;
    e_rd = new[e_T + 1]; e_we = new[e_T + 1]; e_upd = new[e_T + 1];
    e_busy = new[e_T + 1]; e_done = new[e_T + 1];
    e_ra = new[e_T + 1]; e_fa = new[e_T + 1]; e_fd = new[e_T + 1];
    for (int p = 0; p < n; p++) begin
      b = p * plen;
      for (int j = 0; j < plen; j++) e_busy[b + j] = 1'b1;
      for (int j = 0; j < nr; j++) begin
        e_rd[b + j] = 1'b1;
        e_ra[b + j] = f_src[p] + soff[j];
      end
      for (int w = 0; w < nw; w++) begin
        k = b + nr + L + w;
        e_we[k] = 1'b1;
        e_fa[k] = f_dst[p] + doff[w];
        e_fd[k] = (algo == ALGO_BLOCK_AVG) ? avg : rom_val(f_src[p]);
      end
      e_upd[b + nr + L + nw] = 1'b1;
    end
    e_busy[n * plen] = 1'b1;
    e_done[n * plen] = 1'b1;
  endtask

  task automatic run_frame(input logic [2:0] algo, input int n, input logic [7:0] avg, input bit inj);
    build_model(algo, n, avg);
    avg_pixel_in = avg;
    ula_n = n;
    @(negedge clk); ula_clr = 1'b1;
    @(negedge clk); ula_clr = 1'b0;
    algo_in = algo; start = 1'b1; chk_en = 1'b1;
    @(negedge clk); start = 1'b0;
    if (inj) begin
      @(negedge clk); algo_in = ALGO_BLOCK_AVG; start = 1'b1;
      @(negedge clk); start = 1'b0; algo_in = algo;
    end
    for (int w = 0; w < e_T + 40 && chk_k <= e_T; w++) @(negedge clk);
    if (chk_k <= e_T) check("frame_timeout", 32'(chk_k), 32'(e_T + 1));
`ifdef SCALER_PERF_CNT_EN
    check("cycle_count", cycle_count, 32'(e_T));
`endif
  endtask

  task automatic end_frame();
    chk_en = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_fb_we"}, 32'(fb_we), 32'd0);
    check({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
    check({tag, "_fb_data"}, 32'(fb_data), 32'd0);
    check({tag, "_update"}, 32'(update_counters_en), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_selected_algo"}, 32'(selected_algo), 32'd0);
    check({tag, "_p00"}, 32'(p00_out), 32'd0);
    check({tag, "_p11"}, 32'(p11_out), 32'd0);
    check({tag, "_cycle_count"}, cycle_count, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin f_src[i] = '0; f_dst[i] = '0; end
    fork
      compare_loop();
    join_none
    #2;
    check_all_zero("reset_state");
    @(negedge clk); reset = 1'b0;

    // Decimation, two pixels
    f_src[0] = 17'h00280; f_dst[0] = 19'd1000;
    f_src[1] = 17'h00281; f_dst[1] = 19'd1001;
    run_frame(ALGO_DECIMATION, 2, 8'd0, 1'b0);
    check("dec_nwrites", 32'(obs_wa.size()), 32'd2);
    if (obs_wa.size() == 2) begin
      check("dec_addr0", 32'(obs_wa[0]), 32'd1000);
      check("dec_data0", 32'(obs_wd[0]), 32'h80);
      check("dec_data1", 32'(obs_wd[1]), 32'h81);
    end
    if (obs_upd.size() == 2) check("dec_fetch_period", 32'(obs_upd[1] - obs_upd[0]), 32'd6);
    else check("dec_nupdates", 32'(obs_upd.size()), 32'd2);
    check("dec_p00", 32'(p00_out), 32'h81);
    check("dec_selected_algo", 32'(selected_algo), 32'(ALGO_DECIMATION));
    end_frame();

    // Block average
    f_src[0] = 17'd0; f_dst[0] = 19'd5;
    run_frame(ALGO_BLOCK_AVG, 1, 8'd25, 1'b0);
    check("avg_p00", 32'(p00_out), 32'd10);
    check("avg_p01", 32'(p01_out), 32'd20);
    check("avg_p10", 32'(p10_out), 32'd30);
    check("avg_p11", 32'(p11_out), 32'd41);
    check("avg_nreads", 32'(obs_rd.size()), 32'd4);
    if (obs_rd.size() == 4) begin
      check("avg_rd1", 32'(obs_rd[1]), 32'd1);
      check("avg_rd2", 32'(obs_rd[2]), 32'd320);
      check("avg_rd3", 32'(obs_rd[3]), 32'd321);
    end
    if (obs_wd.size() == 1) check("avg_data", 32'(obs_wd[0]), 32'd25);
    else check("avg_nwrites", 32'(obs_wd.size()), 32'd1);
    end_frame();

    // Replication with a start/algo change injected while busy
    f_src[0] = 17'h0005A; f_dst[0] = 19'd1282;
    run_frame(ALGO_REPLICATION, 1, 8'd0, 1'b1);
    check("rep_nwrites", 32'(obs_wa.size()), 32'd4);
    if (obs_wa.size() == 4) begin
      check("rep_addr1", 32'(obs_wa[1]), 32'd1283);
      check("rep_addr2", 32'(obs_wa[2]), 32'd1922);
      check("rep_addr3", 32'(obs_wa[3]), 32'd1923);
      check("rep_data3", 32'(obs_wd[3]), 32'h5A);
    end
    check("rep_selected_algo", 32'(selected_algo), 32'(ALGO_REPLICATION));
    check("rep_p01_held", 32'(p01_out), 32'd20);
    check("rep_p11_held", 32'(p11_out), 32'd41);
    end_frame();

    // Replication with address wrap on both buses
    f_src[0] = 17'h1FFFF; f_dst[0] = 19'h7FFFF;
    run_frame(ALGO_REPLICATION, 1, 8'd0, 1'b0);
    if (obs_wa.size() == 4) begin
      check("wrap_addr1", 32'(obs_wa[1]), 32'd0);
      check("wrap_addr2", 32'(obs_wa[2]), 32'd639);
      check("wrap_data", 32'(obs_wd[0]), 32'hFF);
    end else check("wrap_nwrites", 32'(obs_wa.size()), 32'd4);
    end_frame();

    // Unsupported algorithm
    @(negedge clk); algo_in = 3'b000; start = 1'b1;
    @(posedge clk); #1;
    check("bad_algo_err", 32'(err), 32'd1);
    check("bad_algo_busy", 32'(busy), 32'd0);
    check("bad_algo_rom", 32'(rom_addr), 32'd0);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check("bad_algo_err_clear", 32'(err), 32'd0);
    check("bad_algo_busy2", 32'(busy), 32'd0);
    check("bad_algo_selected", 32'(selected_algo), 32'(ALGO_REPLICATION));

    // Asynchronous reset while waiting on the ROM
    f_src[0] = 17'h00280; f_dst[0] = 19'd1000; ula_n = 1;
    @(negedge clk); ula_clr = 1'b1;
    @(negedge clk); ula_clr = 1'b0; algo_in = ALGO_DECIMATION; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(posedge clk); #2;
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk); reset = 1'b0;
    run_frame(ALGO_DECIMATION, 1, 8'd0, 1'b0);
    if (obs_wa.size() == 1) begin
      check("post_reset_addr", 32'(obs_wa[0]), 32'd1000);
      check("post_reset_data", 32'(obs_wd[0]), 32'h80);
    end else check("post_reset_nwrites", 32'(obs_wa.size()), 32'd1);
    end_frame();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
